// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle for the sequential multiply/divide unit.
// The master drives operations and HI/LO writes; the slave returns status and results.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULTU/MULT/DIVU/DIV unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on a 2*WIDTH accumulator.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div;
  logic               r_div0;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_busy;
  logic               w_done;
  logic               w_sgn_a;
  logic               w_sgn_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_CALC, S_FIXUP: w_busy = 1'b1;
      S_DONE:          w_done = 1'b1;
      default:         ;
    endcase
  end

  // Signed ops run on magnitudes; signs are reapplied in FIXUP.
  assign w_sgn_a = bus.op[0] & bus.a[WIDTH-1];
  assign w_sgn_b = bus.op[0] & bus.b[WIDTH-1];
  assign w_mag_a = w_sgn_a ? -bus.a : bus.a;
  assign w_mag_b = w_sgn_b ? -bus.b : bus.b;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_trial   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_trial >= {1'b0, r_opnd});
  assign w_sub     = w_trial[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_div) begin
      if (w_ge) w_step = {w_sub, r_acc[WIDTH-2:0], 1'b1};
      else      w_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  assign w_prod = r_neg_q ? -r_acc : r_acc;

  // Divide by zero bypasses sign correction: quotient all ones, remainder is the raw dividend.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_div0) begin
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else if (r_div) begin
      w_res_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_res_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_a_raw <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_div0  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wd;
          if (bus.lo_we) r_lo <= bus.wd;
          if (bus.start) begin
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
            r_opnd  <= bus.op[1] ? w_mag_b : w_mag_a;
            r_a_raw <= bus.a;
            r_div   <= bus.op[1];
            r_div0  <= bus.op[1] & (bus.b == '0);
            r_neg_q <= w_sgn_a ^ w_sgn_b;
            r_neg_r <= w_sgn_a;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIXUP: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and HI/LO width (even, >= 4).
REQ-002 The block SHALL have the following ports:
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand or dividend, sampled with start.
- b  input  WIDTH  multiplier or divisor, sampled with start.
- hi_we  input  1  HI write enable (mthi).
- lo_we  input  1  LO write enable (mtlo).
- wd  input  WIDTH  HI/LO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Function
REQ-003 The block SHALL implement FSM states IDLE, CALC, FIXUP and DONE, with transitions IDLE->CALC (start=1), CALC->FIXUP (after iteration WIDTH-1), FIXUP->DONE, and DONE->IDLE.
REQ-004 In IDLE with start=1, the block SHALL latch a, b and op, take operand magnitudes for signed ops, record the result signs, clear the iteration count and enter CALC at the next edge.
REQ-005 CALC SHALL last exactly WIDTH cycles, performing one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle on an internal 2*WIDTH accumulator.
REQ-006 FIXUP SHALL last 1 cycle and apply sign correction: the product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
REQ-007 In DONE, hi/lo SHALL hold the final result and done=1 for exactly that one cycle.
REQ-008 busy SHALL be 1 in CALC and FIXUP, and 0 in IDLE and DONE.
REQ-009 Latency: for start sampled at edge T, done SHALL be high in cycle T+WIDTH+2 (T+34 for WIDTH=32).
REQ-010 start asserted in CALC, FIXUP or DONE SHALL be ignored and not queued.
REQ-011 hi/lo SHALL keep their previous values throughout CALC and FIXUP, and update only on the edge entering DONE.
REQ-012 In IDLE, hi_we/lo_we SHALL load wd into hi/lo at the next edge; in any other state they SHALL be ignored.
REQ-013 If hi_we/lo_we and start are both asserted in IDLE, the write SHALL take effect and the operation SHALL still start; the later DONE result overwrites both registers.
REQ-014 Divide by zero (DIVU or DIV): the block SHALL produce lo = all ones and hi = a unmodified, with no exception flag, and keep the same latency.
REQ-015 DIV of the most-negative value by -1 SHALL produce lo = most-negative value and hi = 0.
REQ-016 Signed division SHALL truncate toward zero.
REQ-017 MULT/MULTU SHALL produce the full 2*WIDTH product in {hi, lo}.

Reset
REQ-018 When reset=1 at an edge, the block SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0 and iteration count=0, regardless of current state.
REQ-019 Reset mid-operation SHALL abort the operation with no done pulse, and the block SHALL accept start on the first edge after reset deasserts.
REQ-020 Reset SHALL take priority over start and hi_we/lo_we in the same cycle.

Verification (WIDTH=32)
REQ-021 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at T+34, hi=0xFFFFFFFE, lo=0x00000001, busy high for cycles T+1..T+33.
REQ-022 MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-023 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-024 DIVU a=0x64 b=0 -> lo=0xFFFFFFFF, hi=0x00000064 at T+34.
REQ-025 Start DIVU, assert start with new operands at T+5, and assert hi_we at T+10 -> both ignored; a single done at T+34 with the first result.
REQ-026 Start MULTU and assert reset at T+10 -> from T+11, busy=0, hi=lo=0, no done pulse; a fresh start at T+12 completes at T+46.
